// File: rtl/paddle_reader.sv
// paddle_reader: polls two serial game pads and steps two clamped paddle positions per poll.
module paddle_reader #(
    parameter int CLK_DIV  = 300,
    parameter int SCREEN_H = 480,
    parameter int PADDLE_H = 64,
    parameter int STEP     = 4,
    parameter int Y_INIT   = 208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data1,
    input  logic       pad_data2,
    output logic [7:0] buttons1,
    output logic [7:0] buttons2,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic       busy,
    output logic       valid
);
    typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, UPDATE, DONE} state_t;

    localparam logic [10:0] HALF   = 11'(CLK_DIV - 1);
    localparam logic [10:0] FULL   = 11'(2 * CLK_DIV - 1);
    localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] STEP11 = 11'(STEP);

    state_t      state, state_n;
    logic [10:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  sr1, sr2;
    logic        sample;

    // Up alone moves toward 0, Down alone toward Y_MAX; both or neither hold.
    function automatic logic [9:0] move(input logic [9:0] y, input logic [7:0] b);
        logic [10:0] w;
        w = {1'b0, y};
        if (b[4] && !b[5])
            w = (w >= STEP11) ? w - STEP11 : 11'd0;
        else if (b[5] && !b[4])
            w = (w + STEP11 > Y_MAX) ? Y_MAX : w + STEP11;
        return w[9:0];
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 11'd1;
        idx_n   = idx;
        sample  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (start) state_n = LATCH;
            end
            LATCH: if (cnt == FULL) begin
                state_n = CLK_HI;
                cnt_n   = '0;
                idx_n   = 3'd1;
                sample  = 1'b1;
            end
            CLK_HI: if (cnt == HALF) begin
                state_n = CLK_LO;
                cnt_n   = '0;
            end
            CLK_LO: if (cnt == HALF) begin
                state_n = (idx == 3'd7) ? UPDATE : CLK_HI;
                cnt_n   = '0;
                idx_n   = idx + 3'd1;
                sample  = 1'b1;
            end
            UPDATE: begin
                state_n = DONE;
                cnt_n   = '0;
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free and exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sr1       <= '0;
            sr2       <= '0;
            buttons1  <= '0;
            buttons2  <= '0;
            paddle1_y <= 10'(Y_INIT);
            paddle2_y <= 10'(Y_INIT);
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            pad_latch <= (state_n == LATCH);
            pad_clk   <= (state_n == CLK_HI);
            valid     <= (state_n == DONE);
            if (sample) begin
                sr1[idx] <= ~pad_data1;
                sr2[idx] <= ~pad_data2;
            end
            if (state == UPDATE) begin
                buttons1  <= sr1;
                buttons2  <= sr2;
                paddle1_y <= move(paddle1_y, sr1);
                paddle2_y <= move(paddle2_y, sr2);
            end
        end
    end
endmodule

// File: tb/tb_paddle_reader.sv
// tb_paddle_reader: two instances (Y_INIT 208 and 2) driven by an emulated pad pair, checked against a poll-level model.
module tb_paddle_reader;
    localparam int D = 2;

    logic       clk = 1'b0, rst = 1'b1, rst_q = 1'b1, start = 1'b0;
    logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
    logic [2:0] pidx = 3'd0;
    logic       pclk_q = 1'b0;
    logic       pad_data1, pad_data2;
    logic [1:0] latch, pclk, busy, valid;
    logic [7:0] b1 [2], b2 [2];
    logic [9:0] y1 [2], y2 [2];

    int tests = 0, fails = 0, nvalid = 0;
    int my1 [2] = '{208, 2};
    int my2 [2] = '{208, 2};
    int init [2] = '{208, 2};
    logic [7:0] mb1 [2] = '{8'h00, 8'h00};
    logic [7:0] mb2 [2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    paddle_reader #(.CLK_DIV(D)) u_a (
        .clk(clk), .rst(rst), .start(start), .pad_latch(latch[0]), .pad_clk(pclk[0]),
        .pad_data1(pad_data1), .pad_data2(pad_data2), .buttons1(b1[0]), .buttons2(b2[0]),
        .paddle1_y(y1[0]), .paddle2_y(y2[0]), .busy(busy[0]), .valid(valid[0]));

    paddle_reader #(.CLK_DIV(D), .Y_INIT(2)) u_b (
        .clk(clk), .rst(rst), .start(start), .pad_latch(latch[1]), .pad_clk(pclk[1]),
        .pad_data1(pad_data1), .pad_data2(pad_data2), .buttons1(b1[1]), .buttons2(b2[1]),
        .paddle1_y(y1[1]), .paddle2_y(y2[1]), .busy(busy[1]), .valid(valid[1]));

    // Pad shift register: latch selects bit 0, each pad_clk rise advances one bit.
    always @(posedge clk) begin
        pclk_q <= pclk[0];
        rst_q  <= rst;
        if (latch[0]) pidx <= 3'd0;
        else if (pclk[0] && !pclk_q) pidx <= pidx + 3'd1;
    end
    assign pad_data1 = ~btn1[pidx];
    assign pad_data2 = ~btn2[pidx];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int step(input int y, input logic [7:0] b);
        if (b[4] && !b[5]) return (y < 4) ? 0 : y - 4;
        if (b[5] && !b[4]) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    always @(negedge clk) begin
        if (rst_q) begin
            for (int i = 0; i < 2; i++) begin
                my1[i] = init[i]; my2[i] = init[i]; mb1[i] = 8'h00; mb2[i] = 8'h00;
            end
        end else if (valid[0]) begin
            nvalid++;
            for (int i = 0; i < 2; i++) begin
                mb1[i] = btn1; mb2[i] = btn2;
                my1[i] = step(my1[i], btn1); my2[i] = step(my2[i], btn2);
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_buttons1[%0d]", i), b1[i], mb1[i]);
            chk($sformatf("model_buttons2[%0d]", i), b2[i], mb2[i]);
            chk($sformatf("model_paddle1[%0d]", i), y1[i], my1[i]);
            chk($sformatf("model_paddle2[%0d]", i), y2[i], my2[i]);
            chk($sformatf("latch_and_clk[%0d]", i), latch[i] & pclk[i], 0);
        end
    end

    task automatic poll(input logic [7:0] a, input logic [7:0] b, input bit extra);
        int lat, lc, pulses, nv0;
        logic prev;
        btn1 = a; btn2 = b;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 1; lc = latch[0]; pulses = 0; prev = pclk[0];
        while (!valid[0] && lat < 100) begin
            chk("busy_in_poll", busy[0], 1);
            start = extra && (lat % 5 == 0);
            @(negedge clk);
            lat++; lc += latch[0]; pulses += (pclk[0] && !prev); prev = pclk[0];
        end
        chk("latency", lat, 34);
        chk("latch_cycles", lc, 4);
        chk("clk_pulses", pulses, 7);
        chk("busy_in_done", busy[0], 1);
        start = extra;
        @(negedge clk); start = 1'b0;
        chk("idle_after_done", busy[0], 0);
        if (extra) begin
            #1 nv0 = nvalid;
            repeat (40) @(negedge clk);
            #1 chk("no_extra_valid", nvalid, nv0);
        end
    endtask

    initial begin
        int nv0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_latch", latch[0], 0);
            chk("idle_clk", pclk[0], 0);
            chk("idle_busy", busy[0], 0);
            chk("idle_valid", valid[0], 0);
        end
        chk("rst_y1", y1[0], 208); chk("rst_y2", y2[0], 208);
        chk("rst_b1", b1[0], 0);   chk("rst_b2", b2[0], 0);

        poll(8'h10, 8'h20, 0);
        chk("p1_b1", b1[0], 8'h10); chk("p1_b2", b2[0], 8'h20);
        chk("p1_y1", y1[0], 204);   chk("p1_y2", y2[0], 212);
        chk("p1_aux_y1", y1[1], 0); chk("p1_aux_y2", y2[1], 6);
        for (int k = 2; k <= 103; k++) poll(8'h10, 8'h20, 0);
        chk("k103_aux_y2", y2[1], 414);
        chk("k103_y1", y1[0], 0); chk("k103_y2", y2[0], 416);
        poll(8'h10, 8'h20, 0);
        chk("clamp_aux_y2", y2[1], 416); chk("clamp_aux_y1", y1[1], 0);
        poll(8'h10, 8'h20, 0);
        chk("hold_aux_y2", y2[1], 416); chk("hold_y1", y1[0], 0);

        poll(8'h20, 8'h00, 0);
        chk("down_y1", y1[0], 4);
        poll(8'h30, 8'h00, 0);
        chk("both_b1", b1[0], 8'h30); chk("both_y1", y1[0], 4);

        poll(8'hA5, 8'h5A, 1);

        btn1 = 8'h01; btn2 = 8'h80;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_lo_busy", busy[0], 1); chk("mid_lo_clk", pclk[0], 0);
        #1 nv0 = nvalid;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", busy[0], 0);   chk("abort_valid", valid[0], 0);
        chk("abort_latch", latch[0], 0); chk("abort_clk", pclk[0], 0);
        chk("abort_b1", b1[0], 0);       chk("abort_b2", b2[0], 0);
        chk("abort_y1", y1[0], 208);     chk("abort_y2", y2[1], 2);
        repeat (40) @(negedge clk);
        #1 chk("abort_no_valid", nvalid, nv0);

        poll(8'hC3, 8'h10, 0);
        chk("after_abort_b1", b1[0], 8'hC3); chk("after_abort_y2", y2[0], 204);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/paddle_reader.md
PADDLE_READER -- requirements
Module: paddle_reader

Interface
REQ-001 Parameter CLK_DIV, default 300: pad clock half-period in clk cycles; legal range 1..1023.
REQ-002 Parameter SCREEN_H, default 480: playfield height in pixels.
REQ-003 Parameter PADDLE_H, default 64: paddle height in pixels.
REQ-004 Parameter STEP, default 4: pixels moved per poll.
REQ-005 Parameter Y_INIT, default 208: paddle top-edge Y after reset.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 start  input  1  one-cycle poll request (e.g. per-frame vsync pulse).
REQ-009 pad_latch  output  1  latch strobe to both pad shift registers.
REQ-010 pad_clk  output  1  shift clock to both pads.
REQ-011 pad_data1  input  1  serial data from pad 1, active-low.
REQ-012 pad_data2  input  1  serial data from pad 2, active-low.
REQ-013 buttons1  output  8  pad 1 button state, 1 = pressed.
REQ-014 buttons2  output  8  pad 2 button state, 1 = pressed.
REQ-015 paddle1_y  output  10  paddle 1 top-edge Y.
REQ-016 paddle2_y  output  10  paddle 2 top-edge Y.
REQ-017 busy  output  1  high while a poll is in progress.
REQ-018 valid  output  1  one-cycle pulse when buttons/paddle outputs are updated.

Function
REQ-019 FSM states IDLE, LATCH, CLK_HI, CLK_LO, UPDATE, DONE; single divider counter and 3-bit bit index.
REQ-020 IDLE: pad_latch=0, pad_clk=0, busy=0; start=1 -> LATCH, counter cleared, bit index 0.
REQ-021 busy is 1 in every state except IDLE; start while busy is ignored (no queueing).
REQ-022 LATCH: pad_latch=1 for exactly 2*CLK_DIV cycles; last LATCH cycle samples bit 0 from both data lines -> CLK_HI, bit index 1.
REQ-023 CLK_HI: pad_clk=1 for CLK_DIV cycles -> CLK_LO.
REQ-024 CLK_LO: pad_clk=0 for CLK_DIV cycles; last cycle samples bit[index]; index 7 -> UPDATE, else index+1 -> CLK_HI.
REQ-025 Samples stored inverted (pressed=1) into internal shift registers; buttons1/2 outputs change only in UPDATE.
REQ-026 Bit map: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-027 UPDATE (1 cycle): copy shift regs to buttons1/2; per paddle: Up only -> y = max(0, y-STEP); Down only -> y = min(SCREEN_H-PADDLE_H, y+STEP); both or neither -> hold.
REQ-028 Clamp arithmetic uses 11-bit intermediates; no wrap below 0 or above SCREEN_H-PADDLE_H.
REQ-029 DONE (1 cycle): valid=1, busy=1 -> IDLE; buttons/paddle outputs already hold new values.
REQ-030 Latency: valid asserted exactly 16*CLK_DIV+2 cycles after the cycle start is sampled high in IDLE.
REQ-031 start in the same cycle as DONE is ignored; start in the following IDLE cycle is accepted.
REQ-032 pad_latch and pad_clk driven from registers, glitch-free, never both high.

Reset
REQ-033 rst=1 at any clk edge, including mid-poll: state=IDLE, pad_latch=0, pad_clk=0, busy=0, valid=0, buttons1=buttons2=0, paddle1_y=paddle2_y=Y_INIT, counters cleared.
REQ-034 Partially shifted data from an aborted poll is discarded; outputs never show a partial frame.
REQ-035 rst has priority over start in the same cycle.

Verification (CLK_DIV=2, defaults otherwise)
REQ-036 Reset then idle -> all outputs per REQ-033; paddles at 208; pad_latch/pad_clk stay 0.
REQ-037 start, pad1 drives Up (bit4 low), pad2 Down (bit5 low) -> valid at cycle 34 after start; buttons1=0x10, buttons2=0x20, paddle1_y=204, paddle2_y=212; exactly 7 pad_clk pulses, latch high 4 cycles.
REQ-038 Paddle1 at 2 with Up -> 0; paddle2 at 414 with Down -> 416 (SCREEN_H-PADDLE_H); further polls hold both.
REQ-039 Up and Down both pressed on pad 1 -> buttons1=0x30, paddle1_y unchanged.
REQ-040 start pulsed repeatedly during busy -> single valid, one poll only; rst asserted mid-CLK_LO -> REQ-033 values next cycle, no valid.
